// File: rtl/if_id_queue.sv
// IF/ID pipeline boundary as a small in-order instruction queue.
// Fetch enqueues with a valid/ready handshake; decode consumes the head unless stalled; flush empties it.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    input  logic              stall,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              enq;
    logic              deq;

    // Ready depends on occupancy only, so a full queue refuses even when the head leaves this cycle.
    assign if_ready = (count != CNT_W'(DEPTH));
    assign id_valid = (count != '0);
    assign enq      = if_valid & if_ready;
    assign deq      = id_valid & ~stall;

    // An empty queue presents an all-zero nop bubble to decode.
    assign id_pc   = id_valid ? pc_mem[rd_ptr]   : '0;
    assign id_inst = id_valid ? inst_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (enq && !deq) begin
                count <= count + CNT_W'(1);
            end else if (deq && !enq) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; the pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (enq && !flush && !rst) begin
            pc_mem[wr_ptr]   <= if_pc;
            inst_mem[wr_ptr] <= if_inst;
        end
    end

    count_in_range: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, then randomized traffic against a queue-based model.
module tb_if_id_queue;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              stall;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [CNT_W-1:0]  count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    typedef struct {
        logic              rst;
        logic              flush;
        logic              if_valid;
        logic [ADDR_W-1:0] pc;
        logic              stall;
        int                exp_count;
        logic              exp_valid;
        logic [ADDR_W-1:0] exp_pc;
        logic              exp_ready;
    } vec_t;

    entry_t model_q[$];
    vec_t   vecs[19];

    if_id_queue #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .if_valid(if_valid),
        .if_pc   (if_pc),
        .if_inst (if_inst),
        .if_ready(if_ready),
        .stall   (stall),
        .id_valid(id_valid),
        .id_pc   (id_pc),
        .id_inst (id_inst),
        .count   (count)
    );

    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
        return pc ^ 32'hDEAD_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; the model advances on the rising edge; outputs are checked 1 time unit later.
    task automatic applyStimulus(input logic r, input logic f, input logic v,
                                 input logic [ADDR_W-1:0] pc, input logic s);
        @(negedge clk);
        rst      = r;
        flush    = f;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst_of(pc);
        stall    = s;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic modelStep();
        bit do_enq;
        bit do_deq;
        entry_t e;
        if (rst) begin
            model_q.delete();
        end else begin
            do_enq = if_valid && (model_q.size() < DEPTH);
            do_deq = (model_q.size() > 0) && !stall;
            if (flush) begin
                model_q.delete();
            end else begin
                if (do_deq) model_q.delete(0);
                if (do_enq) begin
                    e.pc   = if_pc;
                    e.inst = if_inst;
                    model_q.push_back(e);
                end
            end
        end
    endtask

    task automatic checkModel(input string tag);
        logic [ADDR_W-1:0] mpc;
        logic [INST_W-1:0] minst;
        mpc   = (model_q.size() > 0) ? model_q[0].pc   : '0;
        minst = (model_q.size() > 0) ? model_q[0].inst : '0;
        checkOutput({tag, " count"},    64'(count),    64'(model_q.size()));
        checkOutput({tag, " id_valid"}, 64'(id_valid), 64'(model_q.size() > 0));
        checkOutput({tag, " id_pc"},    64'(id_pc),    64'(mpc));
        checkOutput({tag, " id_inst"},  64'(id_inst),  64'(minst));
        checkOutput({tag, " if_ready"}, 64'(if_ready), 64'(model_q.size() < DEPTH));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; stall = 1'b0;

        //            rst   flush iv    pc          stall cnt v     exp_pc      rdy
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h40,  1'b0, 0, 1'b0, 32'h0,   1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 1, 1'b1, 32'h0,   1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h4,   1'b0, 1, 1'b1, 32'h4,   1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h8,   1'b0, 1, 1'b1, 32'h8,   1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 0, 1'b0, 32'h0,   1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h10,  1'b1, 1, 1'b1, 32'h10,  1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h14,  1'b1, 2, 1'b1, 32'h10,  1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h18,  1'b1, 3, 1'b1, 32'h10,  1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h1c,  1'b1, 4, 1'b1, 32'h10,  1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h20,  1'b1, 4, 1'b1, 32'h10,  1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h20,  1'b0, 3, 1'b1, 32'h14,  1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h20,  1'b0, 3, 1'b1, 32'h18,  1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 2, 1'b1, 32'h1c,  1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b1, 32'h20,  1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h30,  1'b1, 2, 1'b1, 32'h20,  1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h34,  1'b1, 3, 1'b1, 32'h20,  1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h38,  1'b0, 0, 1'b0, 32'h0,   1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1, 1'b1, 32'h100, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 0, 1'b0, 32'h0,   1'b1};

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].if_valid, vecs[i].pc, vecs[i].stall);
            checkOutput($sformatf("vec%0d count", i),    64'(count),    64'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d id_valid", i), 64'(id_valid), 64'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d id_pc", i),    64'(id_pc),    64'(vecs[i].exp_pc));
            checkOutput($sformatf("vec%0d id_inst", i),  64'(id_inst),
                        64'(vecs[i].exp_valid ? inst_of(vecs[i].exp_pc) : '0));
            checkOutput($sformatf("vec%0d if_ready", i), 64'(if_ready), 64'(vecs[i].exp_ready));
        end

        // Wrap: continuous fetch with random decode stalls, ordering tracked by the model queue.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h200 + 32'(i) * 4, 1'($urandom_range(0, 1)));
            checkModel($sformatf("wrap%0d", i));
        end

        // Random traffic including occasional flush and reset.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 1)),
                          $urandom,
                          ($urandom_range(0, 2) == 0));
            checkModel($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
